// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
//   PAT_LEN / pattern_t / FILL_W : default 4-bit configuration
//   det_mode_t                   : output timing selector (Mealy / Moore)
//   fill_w(n)                    : width needed to hold a fill level 0..n
package seq_det_pkg;
  localparam int PAT_LEN = 4;
  typedef logic [PAT_LEN-1:0] pattern_t;
  localparam int FILL_W = $clog2(PAT_LEN+1);

  typedef enum logic {DET_MEALY = 1'b0, DET_MOORE = 1'b1} det_mode_t;

  function automatic int fill_w(input int n);
    return $clog2(n+1);
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-in / status-out bundle of the pattern detector.
//   master : source side (drives data_valid, data_in, overlap_en, pat_load, pat_in)
//   slave  : detector side (drives seq_detected, match_count, fill_out)
interface seq_detector_param_if import seq_det_pkg::*; #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) ();
  logic                           data_valid;
  logic                           data_in;
  logic                           overlap_en;
  logic                           pat_load;
  logic [PAT_LEN-1:0]             pat_in;
  logic                           seq_detected;
  logic [CNT_W-1:0]               match_count;
  logic [fill_w(PAT_LEN)-1:0]     fill_out;

  modport master (
    output data_valid, data_in, overlap_en, pat_load, pat_in,
    input  seq_detected, match_count, fill_out
  );
  modport slave (
    input  data_valid, data_in, overlap_en, pat_load, pat_in,
    output seq_detected, match_count, fill_out
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all ones.
//   clk, rst : clock, async active-high reset (count -> 0)
//   i_inc    : increment enable
//   o_cnt    : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial bit-pattern detector.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of seq_detector_param_if
//                in : data_valid, data_in, overlap_en, pat_load, pat_in (MSB first)
//                out: seq_detected, match_count (saturating), fill_out (history depth)
module seq_detector_param import seq_det_pkg::*; #(
  parameter int               PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = 4'b1011,
  parameter bit               MOORE       = 1'b1,
  parameter int               CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam int        FW   = fill_w(PAT_LEN);
  localparam det_mode_t MODE = MOORE ? DET_MOORE : DET_MEALY;

  logic [PAT_LEN-1:0] r_pat;
  // Only the newest PAT_LEN-1 bits are kept: the compare window is those
  // bits plus the live data_in, so the oldest bit would never be read.
  logic [PAT_LEN-2:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic               r_det;

  logic [PAT_LEN-1:0] w_window;
  logic               w_hit;
  logic [FW-1:0]      w_fill_nxt;
  logic [CNT_W-1:0]   w_cnt;

  assign w_window = {r_hist, bus.data_in};
  // fill gates out bits that arrived before reset/load or before a
  // non-overlapping restart.
  assign w_hit = bus.data_valid && !bus.pat_load &&
                 (r_fill >= FW'(PAT_LEN-1)) && (w_window == r_pat);

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_hit && !bus.overlap_en)   w_fill_nxt = '0;
    else if (r_fill != FW'(PAT_LEN)) w_fill_nxt = r_fill + FW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat  <= RST_PATTERN;
      r_hist <= '0;
      r_fill <= '0;
    end else if (bus.pat_load) begin
      r_pat  <= bus.pat_in;
      r_fill <= '0;
    end else if (bus.data_valid) begin
      r_hist <= w_window[PAT_LEN-2:0];
      r_fill <= w_fill_nxt;
    end
  end

  // w_hit is low without data_valid, so the registered pulse lasts one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_det <= 1'b0;
    else       r_det <= w_hit;
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_inc (w_hit),
    .o_cnt (w_cnt)
  );

  assign bus.seq_detected = (MODE == DET_MOORE) ? r_det : w_hit;
  assign bus.match_count  = w_cnt;
  assign bus.fill_out     = r_fill;
endmodule
